// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply/divide unit for the execute stage.
// Multiply: radix-2 shift-add on operand magnitudes, sign applied at the end.
// Divide:   restoring division on magnitudes, quotient truncated toward zero.
// The start edge is edge 0; the result and ready strobe appear on edge WIDTH+1.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

   state_t r_state;
   state_t w_state_next;

   logic [CntW-1:0]    r_count;
   // Multiply: shifted multiplicand magnitude. Divide: low WIDTH bits hold
   // the dividend, which is shifted out MSB-first while quotient bits shift in.
   logic [2*WIDTH-1:0] r_maga;
   // Multiply: multiplier magnitude, shifted right. Divide: divisor magnitude.
   logic [WIDTH-1:0]   r_magb;
   // Multiply: product accumulator. Divide: low WIDTH bits are the remainder.
   logic [2*WIDTH-1:0] r_acc;
   logic               r_neg;
   logic               r_is_mul;

   logic [WIDTH-1:0]   r_result;
   logic               r_exc;
   logic               r_rdy;

   logic               w_start;
   logic [WIDTH-1:0]   w_maga_in;
   logic [WIDTH-1:0]   w_magb_in;

   logic [WIDTH:0]     w_shift;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;

   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic               w_complete;
   logic [WIDTH-1:0]   w_res_next;
   logic               w_exc_next;

   assign w_start = ctrl_MULT | ctrl_DIV;

   // Magnitude of the most negative value stays representable as unsigned.
   assign w_maga_in = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
   assign w_magb_in = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

   // Restoring-division trial: partial remainder with next dividend bit appended.
   assign w_shift = {r_acc[WIDTH-1:0], r_maga[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_magb});
   // When w_ge holds the true difference is below the divisor, so WIDTH bits suffice.
   assign w_diff  = w_shift[WIDTH-1:0] - r_magb;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; a start pulse overrides whatever is in flight.
   always_comb begin
      w_state_next = r_state;
      if (ctrl_MULT) begin
         w_state_next = MUL_RUN;
      end else if (ctrl_DIV) begin
         w_state_next = DIV_RUN;
      end else begin
         unique case (r_state)
            IDLE:    w_state_next = IDLE;
            MUL_RUN: if (r_count == LastCnt) w_state_next = DONE;
            DIV_RUN: if (r_count == LastCnt) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
         endcase
      end
   end

   // Output logic: final sign fix-up and exception detection in DONE.
   always_comb begin
      w_prod     = r_neg ? (~r_acc + 1'b1) : r_acc;
      w_quo      = r_maga[WIDTH-1:0];
      w_complete = (r_state == DONE) && !w_start;
      w_res_next = '0;
      w_exc_next = 1'b0;
      if (r_is_mul) begin
         w_res_next = w_prod[WIDTH-1:0];
         // Upper half plus bit WIDTH-1 must be all zeros or all ones.
         w_exc_next = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
      end else if (r_magb == '0) begin
         w_res_next = '0;
         w_exc_next = 1'b1;
      end else begin
         w_res_next = r_neg ? (~w_quo + 1'b1) : w_quo;
         // Only a positive quotient of magnitude 2^(WIDTH-1) is unrepresentable.
         w_exc_next = !r_neg && w_quo[WIDTH-1];
      end
   end

   // Datapath: operand capture on start, one iteration per running cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_count  <= '0;
         r_maga   <= '0;
         r_magb   <= '0;
         r_acc    <= '0;
         r_neg    <= 1'b0;
         r_is_mul <= 1'b0;
      end else if (w_start) begin
         r_count  <= '0;
         r_maga   <= {{WIDTH{1'b0}}, w_maga_in};
         r_magb   <= w_magb_in;
         r_acc    <= '0;
         r_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         r_is_mul <= ctrl_MULT;
      end else if (r_state == MUL_RUN) begin
         if (r_magb[0]) begin
            r_acc <= r_acc + r_maga;
         end
         r_maga  <= r_maga << 1;
         r_magb  <= r_magb >> 1;
         r_count <= r_count + 1'b1;
      end else if (r_state == DIV_RUN) begin
         r_acc   <= {{WIDTH{1'b0}}, (w_ge ? w_diff : w_shift[WIDTH-1:0])};
         r_maga  <= {{WIDTH{1'b0}}, r_maga[WIDTH-2:0], w_ge};
         r_count <= r_count + 1'b1;
      end
   end

   // Result registers: load on completion, hold otherwise; strobe for one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_result <= '0;
         r_exc    <= 1'b0;
         r_rdy    <= 1'b0;
      end else begin
         r_rdy <= w_complete;
         if (w_complete) begin
            r_result <= w_res_next;
            r_exc    <= w_exc_next;
         end
      end
   end

   assign data_result    = r_result;
   assign data_exception = r_exc;
   assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with hand-computed expected values.
module tb_mult_div_unit;

   logic        clock;
   logic        reset;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int vecs;
   int errs;

   mult_div_unit #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue a start pulse, then watch 40 edges for the single ready strobe.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic m, input logic d,
                         input logic [31:0] exp_res, input logic exp_exc);
      int          lat;
      int          pulses;
      logic [31:0] res_at_rdy;
      logic        exc_at_rdy;
      lat        = -1;
      pulses     = 0;
      res_at_rdy = 'x;
      exc_at_rdy = 1'bx;
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      tick();
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = 32'hDEAD_BEEF;
      data_operandB = 32'h1234_5678;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (data_resultRDY === 1'b1) begin
            pulses++;
            if (lat < 0) begin
               lat        = i;
               res_at_rdy = data_result;
               exc_at_rdy = data_exception;
            end
         end
      end
      chk_int({tag, " latency"}, lat, 33);
      chk_int({tag, " pulses"}, pulses, 1);
      chk32({tag, " result"}, res_at_rdy, exp_res);
      chk32({tag, " exception"}, {31'b0, exc_at_rdy}, {31'b0, exp_exc});
      chk32({tag, " held result"}, data_result, exp_res);
   endtask

   initial begin
      int pulses;
      vecs          = 0;
      errs          = 0;
      reset         = 1'b1;
      data_operandA = '0;
      data_operandB = '0;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk32("reset result", data_result, 32'h0);
      chk32("reset exception", {31'b0, data_exception}, 32'h0);
      chk32("reset rdy", {31'b0, data_resultRDY}, 32'h0);

      run_op("mul 7*-6", 32'd7, 32'hFFFF_FFFA, 1'b1, 1'b0, 32'hFFFF_FFD6, 1'b0);
      tick();
      tick();
      chk32("mul hold", data_result, 32'hFFFF_FFD6);
      chk32("rdy low after", {31'b0, data_resultRDY}, 32'h0);

      run_op("div -17/5", 32'hFFFF_FFEF, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0);
      run_op("div 100/7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 1'b0);
      run_op("div 5/0", 32'd5, 32'd0, 1'b0, 1'b1, 32'h0, 1'b1);
      run_op("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1);
      run_op("mul 2^16*2^16", 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h0, 1'b1);
      run_op("mul min*-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b1);
      run_op("mul 0*-5", 32'd0, 32'hFFFF_FFFB, 1'b1, 1'b0, 32'h0, 1'b0);
      run_op("div 0/-5", 32'd0, 32'hFFFF_FFFB, 1'b0, 1'b1, 32'h0, 1'b0);
      run_op("div -100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 1'b1, 32'd14, 1'b0);

      // Restart: multiply abandoned at cycle 10 by a divide.
      pulses        = 0;
      data_operandA = 32'd3;
      data_operandB = 32'd4;
      ctrl_MULT     = 1'b1;
      tick();
      ctrl_MULT = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         if (data_resultRDY === 1'b1) pulses++;
      end
      chk_int("restart early pulses", pulses, 0);
      run_op("restart div 9/3", 32'd9, 32'd3, 1'b0, 1'b1, 32'd3, 1'b0);

      // Reset at cycle 15 of a multiply.
      pulses        = 0;
      data_operandA = 32'd5;
      data_operandB = 32'd5;
      ctrl_MULT     = 1'b1;
      tick();
      ctrl_MULT = 1'b0;
      for (int i = 1; i <= 14; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk32("midreset result", data_result, 32'h0);
      chk32("midreset exception", {31'b0, data_exception}, 32'h0);
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (data_resultRDY === 1'b1) pulses++;
      end
      chk_int("midreset pulses", pulses, 0);
      chk32("midreset result later", data_result, 32'h0);

      run_op("both starts 6*3", 32'd6, 32'd3, 1'b1, 1'b1, 32'd18, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
